float_subtractor_seq: RTL and testbench

Multi-cycle IEEE-754 binary16 subtractor: computes R = A − B with a valid/ready handshake on both sides. It is the inverse-operation companion to the combinational half-precision adder, and sits in the same floating-point datapath. Alignment and normalization are iterative, one bit per cycle, so latency is data-dependent. Rounding is truncation, which matches the adder.

---
 rtl/float_subtractor_seq.sv | 171 +++++++++++++++++
 tb/tb_float_subtractor_seq.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/float_subtractor_seq.sv
// Multi-cycle binary16 subtractor (R = A - B) with valid/ready handshakes on both sides.
// Alignment and normalization shift one bit per cycle; rounding is truncation.
module float_subtractor_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        inValid,
  output logic        inReady,
  output logic [15:0] R,
  output logic        outValid,
  input  logic        outReady,
  output logic        overflow,
  output logic        underflow,
  output logic        invalid
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ALIGN = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_NORM  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]  r_state;
  logic [15:0] r_R;
  logic        r_overflow;
  logic        r_underflow;
  logic        r_invalid;
  logic        r_sign;
  logic        r_effSub;
  logic [11:0] r_bigMant;
  logic [11:0] r_smallMant;
  logic [11:0] r_sum;
  logic [4:0]  r_exp;
  logic [3:0]  r_d;

  logic [4:0]  w_expA;
  logic [4:0]  w_expB;
  logic [15:0] w_bNeg;
  logic        w_aBig;
  logic [15:0] w_big;
  logic [14:0] w_smallMag;
  logic [4:0]  w_diff;
  logic [3:0]  w_dClamp;
  logic [4:0]  w_expInc;
  logic [4:0]  w_expDec;
  logic        w_accept;

  // Operand decode: subtraction becomes addition of B with its sign flipped.
  assign w_expA     = A[14:10];
  assign w_expB     = B[14:10];
  assign w_bNeg     = {~B[15], B[14:0]};
  assign w_aBig     = (A[14:0] >= B[14:0]);
  assign w_big      = w_aBig ? A : w_bNeg;
  assign w_smallMag = w_aBig ? w_bNeg[14:0] : A[14:0];
  assign w_diff     = w_big[14:10] - w_smallMag[14:10];
  assign w_dClamp   = (w_diff > 5'd11) ? 4'd11 : w_diff[3:0];
  assign w_expInc   = r_exp + 5'd1;
  assign w_expDec   = r_exp - 5'd1;

  assign inReady   = (r_state == S_IDLE) && rst_n;
  assign w_accept  = inValid && inReady;
  assign outValid  = (r_state == S_DONE);
  assign R         = r_R;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
  assign invalid   = r_invalid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_R         <= 16'h0000;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_invalid   <= 1'b0;
      r_sign      <= 1'b0;
      r_effSub    <= 1'b0;
      r_bigMant   <= 12'd0;
      r_smallMant <= 12'd0;
      r_sum       <= 12'd0;
      r_exp       <= 5'd0;
      r_d         <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_expA == 5'd31 || w_expB == 5'd31) begin
              r_R         <= 16'h7E00;
              r_overflow  <= 1'b0;
              r_underflow <= 1'b0;
              r_invalid   <= 1'b1;
              r_state     <= S_DONE;
            end else if (w_expA == 5'd0 || w_expB == 5'd0) begin
              // Denormals are flushed, so exponent 0 means the operand is zero.
              if (w_expA == 5'd0 && w_expB == 5'd0)
                r_R <= 16'h0000;
              else if (w_expB == 5'd0)
                r_R <= A;
              else
                r_R <= w_bNeg;
              r_overflow  <= 1'b0;
              r_underflow <= 1'b0;
              r_invalid   <= 1'b0;
              r_state     <= S_DONE;
            end else begin
              r_bigMant   <= {2'b01, w_big[9:0]};
              r_smallMant <= {2'b01, w_smallMag[9:0]};
              r_exp       <= w_big[14:10];
              r_sign      <= w_big[15];
              r_effSub    <= A[15] ^ w_bNeg[15];
              r_d         <= w_dClamp;
              r_state     <= (w_dClamp != 4'd0) ? S_ALIGN : S_ADD;
            end
          end
        end
        S_ALIGN: begin
          r_smallMant <= r_smallMant >> 1;
          r_d         <= r_d - 4'd1;
          if (r_d == 4'd1)
            r_state <= S_ADD;
        end
        S_ADD: begin
          // big >= small by construction, so the difference never goes negative.
          r_sum   <= r_effSub ? (r_bigMant - r_smallMant) : (r_bigMant + r_smallMant);
          r_state <= S_NORM;
        end
        S_NORM: begin
          if (r_sum == 12'd0) begin
            r_R         <= 16'h0000;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_invalid   <= 1'b0;
            r_state     <= S_DONE;
          end else if (r_sum[11]) begin
            r_sum <= r_sum >> 1;
            r_exp <= w_expInc;
            if (w_expInc == 5'd31) begin
              r_R         <= {r_sign, 15'h7C00};
              r_overflow  <= 1'b1;
              r_underflow <= 1'b0;
              r_invalid   <= 1'b0;
              r_state     <= S_DONE;
            end
          end else if (r_sum[10]) begin
            r_R         <= {r_sign, r_exp, r_sum[9:0]};
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_invalid   <= 1'b0;
            r_state     <= S_DONE;
          end else begin
            r_sum <= r_sum << 1;
            r_exp <= w_expDec;
            if (w_expDec == 5'd0) begin
              r_R         <= {r_sign, 15'd0};
              r_overflow  <= 1'b0;
              r_underflow <= 1'b1;
              r_invalid   <= 1'b0;
              r_state     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (outReady)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_subtractor_seq.sv
// Directed-vector bench for float_subtractor_seq: results, flags, latency,
// backpressure and mid-operation reset, all against hand-computed values.
module tb_float_subtractor_seq;

  logic        clk;
  logic        rst_n;
  logic [15:0] A;
  logic [15:0] B;
  logic        inValid;
  logic        inReady;
  logic [15:0] R;
  logic        outValid;
  logic        outReady;
  logic        overflow;
  logic        underflow;
  logic        invalid;

  int vectorCount;
  int missCount;

  float_subtractor_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .inValid   (inValid),
    .inReady   (inReady),
    .R         (R),
    .outValid  (outValid),
    .outReady  (outReady),
    .overflow  (overflow),
    .underflow (underflow),
    .invalid   (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents operands, waits for the accept edge, then counts cycles until outValid.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, output int lat);
    int guard;
    A       = a;
    B       = b;
    inValid = 1'b1;
    guard   = 0;
    while (!inReady && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!inReady) checkOutput("acceptTimeout", 32'd1, 32'd0);
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    lat     = 1;
    while (!outValid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!outValid) checkOutput("doneTimeout", 32'd1, 32'd0);
  endtask

  task automatic popResult();
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    checkOutput("outValidAfterPop", {31'd0, outValid}, 32'd0);
  endtask

  // expFlags = {overflow, underflow, invalid}; expLat < 0 skips the latency check.
  task automatic runVector(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] expR, input logic [2:0] expFlags,
                           input int expLat, input bit pop);
    int lat;
    applyStimulus(a, b, lat);
    checkOutput({tag, ".R"}, {16'd0, R}, {16'd0, expR});
    checkOutput({tag, ".flags"}, {29'd0, overflow, underflow, invalid}, {29'd0, expFlags});
    if (expLat >= 0) checkOutput({tag, ".latency"}, lat, expLat);
    if (pop) popResult();
  endtask

  initial begin
    vectorCount = 0;
    missCount   = 0;
    rst_n    = 1'b0;
    A        = 16'h0000;
    B        = 16'h0000;
    inValid  = 1'b0;
    outReady = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("reset.R", {16'd0, R}, 32'h0);
    checkOutput("reset.outValid", {31'd0, outValid}, 32'd0);
    checkOutput("reset.flags", {29'd0, overflow, underflow, invalid}, 32'd0);
    checkOutput("reset.inReady", {31'd0, inReady}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("release.inReady", {31'd0, inReady}, 32'd1);

    runVector("sub1p5m1",   16'h3E00, 16'h3C00, 16'h3800, 3'b000, 4, 1'b1);
    runVector("addCarry",   16'h3C00, 16'hBC00, 16'h4000, 3'b000, 4, 1'b1);
    runVector("selfCancel", 16'h3C00, 16'h3C00, 16'h0000, 3'b000, 3, 1'b1);
    runVector("swapNeg",    16'h3C00, 16'h4000, 16'hBC00, 3'b000, 5, 1'b1);
    runVector("addAlign",   16'h4000, 16'hBC00, 16'h4200, 3'b000, 4, 1'b1);
    runVector("twoMinus1",  16'h4000, 16'h3C00, 16'h3C00, 3'b000, 5, 1'b1);
    runVector("overflow",   16'h7BFF, 16'hFBFF, 16'h7C00, 3'b100, 3, 1'b1);
    runVector("denormB",    16'h0400, 16'h03FF, 16'h0400, 3'b000, 1, 1'b1);
    runVector("zeroA",      16'h0000, 16'h3C00, 16'hBC00, 3'b000, 1, 1'b1);
    runVector("infA",       16'h7C00, 16'h3C00, 16'h7E00, 3'b001, 1, 1'b1);

    // Backpressure: hold the result, ignore a stray operand, then resume.
    runVector("bpVector",   16'h3C00, 16'hBC00, 16'h4000, 3'b000, 4, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        A = 16'h7C00; B = 16'h3C00; inValid = 1'b1;
      end else begin
        inValid = 1'b0;
      end
      @(negedge clk);
      checkOutput("bp.R", {16'd0, R}, 32'h4000);
      checkOutput("bp.outValid", {31'd0, outValid}, 32'd1);
      checkOutput("bp.inReady", {31'd0, inReady}, 32'd0);
      checkOutput("bp.flags", {29'd0, overflow, underflow, invalid}, 32'd0);
    end
    inValid = 1'b0;
    popResult();
    checkOutput("bp.inReadyAfterPop", {31'd0, inReady}, 32'd1);
    checkOutput("bp.RHeldInIdle", {16'd0, R}, 32'h4000);
    runVector("bpNext",     16'h3E00, 16'h3C00, 16'h3800, 3'b000, 4, 1'b1);

    // Mid-operation reset during the long clamped alignment.
    A = 16'h3C00; B = 16'h1000; inValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midReset.outValid", {31'd0, outValid}, 32'd0);
    checkOutput("midReset.R", {16'd0, R}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midReset.inReady", {31'd0, inReady}, 32'd1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checkOutput("midReset.noOutput", {31'd0, outValid}, 32'd0);
    end
    runVector("afterReset", 16'h3E00, 16'h3C00, 16'h3800, 3'b000, 4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
